// File: rtl/mux_sel_scheduler.sv
// Round-robin 2:1 mux select generator; grants capped at HOLD cycles under contention.
// Latency: 1 cycle, all outputs registered; no backpressure, en=0 freezes every register.
module mux_sel_scheduler #(
   parameter int HOLD = 4,
   parameter int SWW  = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           req0,
   input  logic           req1,
   output logic           sel,
   output logic           gnt0,
   output logic           gnt1,
   output logic           busy,
   output logic [SWW-1:0] switch_cnt
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   localparam logic [7:0] CNT_MAX = 8'(HOLD - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic       last, last_nx;
   logic       sel_nx;
   logic       go, gto, swap;
   logic       own, req_own, req_oth;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      last_nx  = last;
      go       = 1'b0;
      gto      = 1'b0;
      swap     = 1'b0;
      own      = (state == GRANT1);
      req_own  = own ? req1 : req0;
      req_oth  = own ? req0 : req1;

      case (state)
         IDLE: begin
            if (req0 && req1) begin
               go  = 1'b1;
               gto = ~last;
            end else if (req0 || req1) begin
               go  = 1'b1;
               gto = req1;
            end
         end
         GRANT0, GRANT1: begin
            if (!req_own) begin
               if (req_oth) begin
                  go   = 1'b1;
                  gto  = ~own;
                  swap = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end else if (cnt == CNT_MAX) begin
               // Dwell expired: yield if the other side waits, else re-grant self.
               go   = 1'b1;
               gto  = req_oth ? ~own : own;
               swap = req_oth;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (go) begin
         state_nx = gto ? GRANT1 : GRANT0;
         cnt_nx   = 8'd0;
         last_nx  = gto;
      end

      // In IDLE the select holds so the mux output does not glitch.
      case (state_nx)
         GRANT0:  sel_nx = 1'b0;
         GRANT1:  sel_nx = 1'b1;
         default: sel_nx = sel;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         last       <= 1'b1;
         sel        <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         busy       <= 1'b0;
         switch_cnt <= '0;
      end else if (en) begin
         state <= state_nx;
         cnt   <= cnt_nx;
         last  <= last_nx;
         sel   <= sel_nx;
         gnt0  <= (state_nx == GRANT0);
         gnt1  <= (state_nx == GRANT1);
         busy  <= (state_nx != IDLE);
         if (swap)
            switch_cnt <= switch_cnt + SWW'(1);
      end
   end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: directed scenarios plus randomized traffic against a
// holder/dwell reference model.
module tb_mux_sel_scheduler;

   localparam int HOLD = 4;
   localparam int SWW  = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b1;
   logic           req0 = 1'b0;
   logic           req1 = 1'b0;
   logic           sel, gnt0, gnt1, busy;
   logic [SWW-1:0] switch_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model: who holds the mux (-1 none), how long, who was last, handovers.
   int m_holder = -1;
   int m_dwell  = 0;
   int m_last   = 1;
   int m_sel    = 0;
   int m_sw     = 0;

   mux_sel_scheduler #(.HOLD(HOLD), .SWW(SWW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req0       (req0),
      .req1       (req1),
      .sel        (sel),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .busy       (busy),
      .switch_cnt (switch_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_grant(input int n, input bit handover);
      m_holder = n;
      m_dwell  = 0;
      m_last   = n;
      if (handover) m_sw = (m_sw + 1) % (1 << SWW);
   endtask

   task automatic model_step(input bit r0, input bit r1, input bit e, input bit rs);
      bit mine, other;
      if (rs) begin
         m_holder = -1; m_dwell = 0; m_last = 1; m_sel = 0; m_sw = 0;
      end else if (e) begin
         if (m_holder < 0) begin
            if (r0 && r1)  model_grant(1 - m_last, 0);
            else if (r0)   model_grant(0, 0);
            else if (r1)   model_grant(1, 0);
         end else begin
            mine  = (m_holder == 1) ? r1 : r0;
            other = (m_holder == 1) ? r0 : r1;
            if (!mine) begin
               if (other) model_grant(1 - m_holder, 1);
               else       m_holder = -1;
            end else if (m_dwell == HOLD - 1) begin
               if (other) model_grant(1 - m_holder, 1);
               else       m_dwell = 0;
            end else begin
               m_dwell++;
            end
         end
         if (m_holder >= 0) m_sel = m_holder;
      end
   endtask

   task automatic step(input bit r0, input bit r1, input bit e, input bit rs);
      req0 = r0; req1 = r1; en = e; rst = rs;
      @(posedge clk);
      model_step(r0, r1, e, rs);
      #1;
   endtask

   function automatic logic [SWW+3:0] exp_vec();
      return {m_sel[0], m_holder == 0, m_holder == 1, m_holder >= 0, m_sw[SWW-1:0]};
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1, 1, 1, 1);
         tests++;
         if ({sel, gnt0, gnt1, busy, switch_cnt} !== '0) begin
            fails++;
            $display("FAIL reset cyc%0d got %h want 0", i, {sel, gnt0, gnt1, busy, switch_cnt});
         end
      end
   endtask

   task automatic test_single();
      step(0, 0, 1, 1);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 1, 0);
         tests++;
         if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0 || switch_cnt !== '0) begin
            fails++;
            $display("FAIL single cyc%0d got g0=%b g1=%b sel=%b sw=%0d want g0=1 g1=0 sel=0 sw=0",
                     i, gnt0, gnt1, sel, switch_cnt);
         end
         tests++;
         if ({sel, gnt0, gnt1, busy, switch_cnt} !== exp_vec()) begin
            fails++;
            $display("FAIL single_model cyc%0d got %h want %h", i, {sel, gnt0, gnt1, busy, switch_cnt}, exp_vec());
         end
      end
   endtask

   task automatic test_contention();
      int blk;
      step(0, 0, 1, 1);
      for (int i = 1; i <= 12; i++) begin
         step(1, 1, 1, 0);
         blk = (i - 1) / HOLD;
         tests++;
         if (gnt1 !== blk[0] || gnt0 !== ~blk[0] || sel !== blk[0] || switch_cnt !== SWW'(blk)) begin
            fails++;
            $display("FAIL contention cyc%0d got g0=%b g1=%b sel=%b sw=%0d want g1=%0d sw=%0d",
                     i, gnt0, gnt1, sel, switch_cnt, blk % 2, blk);
         end
      end
   endtask

   task automatic test_drop();
      step(0, 0, 1, 1);
      for (int i = 0; i < 6; i++) step(1, 1, 1, 0);
      step(0, 0, 1, 0);
      tests++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0 || sel !== 1'b1) begin
         fails++;
         $display("FAIL drop_idle got g0=%b g1=%b busy=%b sel=%b want 0 0 0 1", gnt0, gnt1, busy, sel);
      end
      step(1, 1, 1, 0);
      tests++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
         fails++;
         $display("FAIL drop_regrant got g0=%b g1=%b sel=%b want 1 0 0", gnt0, gnt1, sel);
      end
   endtask

   task automatic test_freeze();
      logic exp_g1 [3] = '{1'b0, 1'b0, 1'b1};
      step(0, 0, 1, 1);
      step(1, 0, 1, 0);
      step(1, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'($urandom), 1'($urandom), 0, 0);
         tests++;
         if ({sel, gnt0, gnt1, busy, switch_cnt} !== exp_vec() || gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL freeze cyc%0d got %h want %h", i, {sel, gnt0, gnt1, busy, switch_cnt}, exp_vec());
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 0);
         tests++;
         if (gnt1 !== exp_g1[i] || gnt0 !== ~exp_g1[i]) begin
            fails++;
            $display("FAIL resume cyc%0d got g0=%b g1=%b want g1=%b", i, gnt0, gnt1, exp_g1[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 1, 1);
      for (int i = 0; i < 13; i++) step(1, 1, 1, 0);
      tests++;
      if (gnt1 !== 1'b1 || switch_cnt !== SWW'(3)) begin
         fails++;
         $display("FAIL pre_reset got g1=%b sw=%0d want g1=1 sw=3", gnt1, switch_cnt);
      end
      step(1, 1, 1, 1);
      tests++;
      if ({sel, gnt0, gnt1, busy, switch_cnt} !== '0) begin
         fails++;
         $display("FAIL reset_mid got %h want 0", {sel, gnt0, gnt1, busy, switch_cnt});
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 1);
      for (int i = 0; i < 256 * HOLD; i++) step(1, 1, 1, 0);
      tests++;
      if (switch_cnt !== SWW'(255)) begin
         fails++;
         $display("FAIL wrap_pre got sw=%0d want 255", switch_cnt);
      end
      step(1, 1, 1, 0);
      tests++;
      if (switch_cnt !== '0 || gnt0 !== 1'b1) begin
         fails++;
         $display("FAIL wrap got sw=%0d g0=%b want sw=0 g0=1", switch_cnt, gnt0);
      end
   endtask

   task automatic test_random();
      bit r0, r1, e, rs;
      step(0, 0, 1, 1);
      for (int i = 0; i < 2000; i++) begin
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         e  = ($urandom_range(0, 7) != 0);
         rs = ($urandom_range(0, 63) == 0);
         step(r0, r1, e, rs);
         tests++;
         if ({sel, gnt0, gnt1, busy, switch_cnt} !== exp_vec()) begin
            fails++;
            $display("FAIL random cyc%0d got %h want %h", i, {sel, gnt0, gnt1, busy, switch_cnt}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_drop();
      test_freeze();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
